pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/ras_stack.sv | 68 ++++++
 rtl/pc_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared definitions for the PC sequencer: the next-PC source selector and
// the sequential step size.
package pc_seq_pkg;

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_EXC,
        SRC_HOLD,
        SRC_RET,
        SRC_JUMP,
        SRC_BRANCH,
        SRC_SEQ
    } next_src_e;

endpackage

// File: rtl/ras_stack.sv
// ras_stack
// Circular return-address stack. The pointer addresses the most recent
// entry. A push while full overwrites the oldest entry, which sits one slot
// past the pointer, and raises a one-cycle overflow pulse.
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   push        write push_data as the new top entry
//   pop         drop the top entry (ignored when empty)
//   push_data   address to push
//   top         current top entry (valid only when not empty)
//   empty/full  derived from the registered entry count
//   overflow    registered pulse: the last push discarded the oldest entry
module ras_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [CNT_W-1:0] count;

    assign ptr_inc = ptr + PTR_W'(1);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign top     = mem[ptr];

    // Contents are not reset; the count guarantees nothing stale is read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[ptr_inc] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full;
            if (push) begin
                ptr <= ptr_inc;
                if (!full) begin
                    count <= count + CNT_W'(1);
                end
            end else if (pop && !empty) begin
                ptr   <= ptr - PTR_W'(1);
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program counter with prioritised next-PC selection and a return-address
// stack for call/return prediction.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   stall               freeze pc and stack
//   exc                 redirect to EXC_VECTOR (beats stall)
//   ret, ra_fallback    return via stack, or ra_fallback when empty
//   jump, jump_target   unconditional redirect; with link also pushes pc+4
//   link                call qualifier for jump
//   branch_taken/target conditional redirect
//   pc, pc_plus4        registered pc and its combinational successor
//   ras_empty/ras_full  stack occupancy
//   ras_overflow        pulse: a push discarded the oldest entry
//   misalign            pulse: the taken redirect target had bits [1:0] set
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_PC   = '0,
    parameter logic [31:0]       EXC_VECTOR = 32'h0000_0180,
    parameter int unsigned       RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             exc,
    input  logic             ret,
    input  logic [WIDTH-1:0] ra_fallback,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             link,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             misalign
);

    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

    next_src_e        src;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] raw_target;
    logic [WIDTH-1:0] ras_top;
    logic             redirect;
    logic             ras_push;
    logic             ras_pop;

    assign pc_plus4 = pc + WIDTH'(PC_STEP);

    always_comb begin
        src = SRC_SEQ;
        if (reset)             src = SRC_RESET;
        else if (exc)          src = SRC_EXC;
        else if (stall)        src = SRC_HOLD;
        else if (ret)          src = SRC_RET;
        else if (jump)         src = SRC_JUMP;
        else if (branch_taken) src = SRC_BRANCH;
    end

    always_comb begin
        pc_next    = pc_plus4;
        raw_target = branch_target;
        redirect   = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        case (src)
            SRC_RESET: pc_next = RESET_PC;
            SRC_EXC:   pc_next = EXC_PC;
            SRC_HOLD:  pc_next = pc;
            SRC_RET: begin
                redirect   = 1'b1;
                raw_target = ras_empty ? ra_fallback : ras_top;
                ras_pop    = !ras_empty;
            end
            SRC_JUMP: begin
                redirect   = 1'b1;
                raw_target = jump_target;
                ras_push   = link;
            end
            SRC_BRANCH: begin
                redirect   = 1'b1;
                raw_target = branch_target;
            end
            default: pc_next = pc_plus4;
        endcase
        // Redirect targets are word-aligned by dropping the low bits.
        if (redirect) begin
            pc_next = {raw_target[WIDTH-1:2], 2'b00};
        end
    end

    // Reset is folded into src, so the pc register needs no separate branch.
    always_ff @(posedge clk) begin
        pc <= pc_next;
        if (reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= redirect && (raw_target[1:0] != 2'b00);
        end
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam logic [31:0] EXC_PC  = 32'h0000_0180;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, exc, ret, jump, link, branch_taken;
    logic [31:0] ra_fallback, jump_target, branch_target;
    logic [31:0] pc, pc_plus4;
    logic        ras_empty, ras_full, ras_overflow, misalign;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pc value, stack as a queue (back = newest).
    logic [31:0] m_pc;
    logic [31:0] m_stack [$];
    logic        m_ovf, m_mis;

    always #5 clk = ~clk;

    pc_sequencer #(
        .WIDTH      (32),
        .RESET_PC   (RST_PC),
        .EXC_VECTOR (EXC_PC),
        .RAS_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .exc           (exc),
        .ret           (ret),
        .ra_fallback   (ra_fallback),
        .jump          (jump),
        .jump_target   (jump_target),
        .link          (link),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .misalign      (misalign)
    );

    typedef struct {
        logic [6:0]  ctl;    // {reset, exc, stall, ret, link, jump, branch}
        logic [31:0] ra;
        logic [31:0] jt;
        logic [31:0] bt;
        logic [31:0] e_pc;
        logic [3:0]  e_flags; // {empty, full, overflow, misalign}
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic [6:0] ctl, input logic [31:0] ra, jt, bt, epc,
                                input logic [3:0] ef);
        vec_t v;
        v.ctl = ctl; v.ra = ra; v.jt = jt; v.bt = bt; v.e_pc = epc; v.e_flags = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [31:0] ra, jt, bt);
        {reset, exc, stall, ret, link, jump, branch_taken} = ctl;
        ra_fallback = ra; jump_target = jt; branch_target = bt;
    endtask

    // Behavioural model of one clock edge, written from the priority rules.
    task automatic model_step();
        logic [31:0] tgt;
        logic        redir;
        m_ovf = 1'b0;
        m_mis = 1'b0;
        if (reset) begin
            m_pc = RST_PC;
            m_stack.delete();
        end else if (exc) begin
            m_pc = EXC_PC;
        end else if (!stall) begin
            redir = 1'b1;
            tgt   = 32'h0;
            if (ret) begin
                if (m_stack.size() > 0) tgt = m_stack.pop_back();
                else                    tgt = ra_fallback;
            end else if (jump) begin
                tgt = jump_target;
                if (link) begin
                    m_stack.push_back(m_pc + 32'd4);
                    if (m_stack.size() > DEPTH) begin
                        void'(m_stack.pop_front());
                        m_ovf = 1'b1;
                    end
                end
            end else if (branch_taken) begin
                tgt = branch_target;
            end else begin
                redir = 1'b0;
                m_pc  = m_pc + 32'd4;
            end
            if (redir) begin
                m_mis = (tgt % 4) != 0;
                m_pc  = tgt - (tgt % 4);
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".pc"},       pc,           m_pc);
        check({tag, ".pc_plus4"}, pc_plus4,     m_pc + 32'd4);
        check({tag, ".empty"},    32'(ras_empty),    32'(m_stack.size() == 0));
        check({tag, ".full"},     32'(ras_full),     32'(m_stack.size() == DEPTH));
        check({tag, ".overflow"}, 32'(ras_overflow), 32'(m_ovf));
        check({tag, ".misalign"}, 32'(misalign),     32'(m_mis));
    endtask

    task automatic cycle(input string tag, input logic [6:0] ctl, input logic [31:0] ra, jt, bt);
        drive(ctl, ra, jt, bt);
        @(posedge clk);
        model_step();
        #1;
        compare_model(tag);
    endtask

    task automatic expect_now(input string tag, input logic [31:0] epc, input logic [3:0] ef);
        check({tag, ".pc"},    pc, epc);
        check({tag, ".flags"}, 32'({ras_empty, ras_full, ras_overflow, misalign}), 32'(ef));
    endtask

    initial begin
        m_pc = RST_PC;
        m_ovf = 1'b0;
        m_mis = 1'b0;
        drive(7'b1000000, 32'h0, 32'h0, 32'h0);

        //                 ctl          ra            jt            bt           exp pc        flags
        tbl.push_back(mk(7'b1000000, 32'h0,        32'h0,        32'h0,       32'h0,        4'b1000));
        tbl.push_back(mk(7'b0000000, 32'h0,        32'h0,        32'h0,       32'h4,        4'b1000));
        tbl.push_back(mk(7'b0000000, 32'h0,        32'h0,        32'h0,       32'h8,        4'b1000));
        tbl.push_back(mk(7'b0000000, 32'h0,        32'h0,        32'h0,       32'hC,        4'b1000));
        tbl.push_back(mk(7'b0000010, 32'h0,        32'h100,      32'h0,       32'h100,      4'b1000));
        tbl.push_back(mk(7'b0000110, 32'h0,        32'h400,      32'h0,       32'h400,      4'b0000));
        tbl.push_back(mk(7'b0000000, 32'h0,        32'h0,        32'h0,       32'h404,      4'b0000));
        tbl.push_back(mk(7'b0001000, 32'h0,        32'h0,        32'h0,       32'h104,      4'b1000));
        tbl.push_back(mk(7'b0110010, 32'h0,        32'h800,      32'h0,       32'h180,      4'b1000));
        tbl.push_back(mk(7'b0000110, 32'h0,        32'h300,      32'h0,       32'h300,      4'b0000));
        tbl.push_back(mk(7'b0010000, 32'h0,        32'h0,        32'h0,       32'h300,      4'b0000));
        tbl.push_back(mk(7'b0011000, 32'h0,        32'h0,        32'h0,       32'h300,      4'b0000));
        tbl.push_back(mk(7'b0010110, 32'h0,        32'h900,      32'h0,       32'h300,      4'b0000));
        tbl.push_back(mk(7'b0001000, 32'h0,        32'h0,        32'h0,       32'h184,      4'b1000));
        tbl.push_back(mk(7'b0000001, 32'h0,        32'h0,        32'h203,     32'h200,      4'b1001));
        tbl.push_back(mk(7'b0000000, 32'h0,        32'h0,        32'h0,       32'h204,      4'b1000));
        tbl.push_back(mk(7'b0001000, 32'hDEADBEE0, 32'h0,        32'h0,       32'hDEADBEE0, 4'b1000));
        tbl.push_back(mk(7'b0000010, 32'h0,        32'hFFFFFFFC, 32'h0,       32'hFFFFFFFC, 4'b1000));
        tbl.push_back(mk(7'b0000000, 32'h0,        32'h0,        32'h0,       32'h0,        4'b1000));
        tbl.push_back(mk(7'b0001000, 32'h1001,     32'h0,        32'h0,       32'h1000,     4'b1001));
        tbl.push_back(mk(7'b0000100, 32'h0,        32'h0,        32'h0,       32'h1004,     4'b1000));
        tbl.push_back(mk(7'b0001100, 32'h50,       32'h0,        32'h0,       32'h50,       4'b1000));
        tbl.push_back(mk(7'b0000011, 32'h0,        32'h600,      32'h700,     32'h600,      4'b1000));
        tbl.push_back(mk(7'b0001011, 32'h20,       32'h600,      32'h700,     32'h20,       4'b1000));

        for (int i = 0; i < tbl.size(); i++) begin
            cycle($sformatf("vec%0d", i), tbl[i].ctl, tbl[i].ra, tbl[i].jt, tbl[i].bt);
            expect_now($sformatf("vec%0d.exp", i), tbl[i].e_pc, tbl[i].e_flags);
            check($sformatf("vec%0d.exp.pc_plus4", i), pc_plus4, tbl[i].e_pc + 32'd4);
        end

        // Five nested calls into a four-deep stack, then five returns.
        cycle("nest.rst", 7'b1000000, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("nest.call%0d", i), 7'b0000110, 32'h0, 32'h1000 * (i + 1), 32'h0);
            expect_now($sformatf("nest.call%0d.exp", i), 32'h1000 * (i + 1),
                       {1'b0, (i >= 3), (i == 4), 1'b0});
        end
        cycle("nest.idle", 7'b0000000, 32'h0, 32'h0, 32'h0);
        expect_now("nest.idle.exp", 32'h5004, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("nest.ret%0d", i), 7'b0001000, 32'hDEADBEE0, 32'h0, 32'h0);
            expect_now($sformatf("nest.ret%0d.exp", i),
                       (i < 4) ? (32'h1000 * (4 - i) + 32'h4) : 32'hDEADBEE0,
                       {(i >= 3), 3'b000});
        end

        // Reset in the middle of a call chain with redirects pending.
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("mid.call%0d", i), 7'b0000110, 32'h0, 32'h2000 + 32'h100 * i, 32'h0);
        end
        expect_now("mid.before", 32'h2200, 4'b0000);
        cycle("mid.rst", 7'b1100111, 32'h0, 32'h7003, 32'h8001);
        expect_now("mid.rst.exp", RST_PC, 4'b1000);
        cycle("mid.ret", 7'b0001000, 32'h40, 32'h0, 32'h0);
        expect_now("mid.ret.exp", 32'h40, 4'b1000);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [6:0]  ctl;
            logic [31:0] ra, jt, bt;
            ctl[6] = ($urandom_range(0, 99) < 2);
            ctl[5] = ($urandom_range(0, 99) < 6);
            ctl[4] = ($urandom_range(0, 99) < 12);
            ctl[3] = ($urandom_range(0, 99) < 20);
            ctl[2] = ($urandom_range(0, 99) < 50);
            ctl[1] = ($urandom_range(0, 99) < 30);
            ctl[0] = ($urandom_range(0, 99) < 25);
            ra = $urandom();
            jt = $urandom();
            bt = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                ra[1:0] = 2'b00; jt[1:0] = 2'b00; bt[1:0] = 2'b00;
            end
            cycle($sformatf("rnd%0d", i), ctl, ra, jt, bt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
